// File: rtl/mul_err_pkg.sv
// Shared types and default sizing for the approximate-multiplier error accumulator.
package mul_err_pkg;

  typedef enum logic [2:0] {StIdle, StRun, StUpd, StDiv, StDone} state_e;

  localparam int unsigned W_DEF       = 8;
  localparam int unsigned RE_FRAC_DEF = 16;
  localparam int unsigned DIV_CYC     = 2 * W_DEF + RE_FRAC_DEF;
  localparam int unsigned QUO_W       = DIV_CYC;

  // One quotient bit per cycle, so divide latency equals the dividend width.
  function automatic int unsigned div_cycles(int unsigned w, int unsigned re_frac);
    return 2 * w + re_frac;
  endfunction

endpackage

// File: rtl/mul_err_divider.sv
// Unsigned radix-2 restoring divider; the first quotient bit is resolved in the start cycle,
// so a DVD_W-bit dividend takes DVD_W cycles and done pulses one cycle after the last step.
module mul_err_divider
  import mul_err_pkg::*;
#(
  parameter int unsigned DVD_W = QUO_W,
  parameter int unsigned DVS_W = 2 * W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DVD_W-1:0] quotient
);

  localparam int unsigned CW = $clog2(DVD_W + 1);

  logic [DVS_W-1:0] rem_q, rem_in, rem_nxt, dvs_q, dvs_in;
  logic [DVD_W-1:0] quo_q, quo_in, quo_nxt;
  logic [CW-1:0]    cnt_q;
  logic [DVS_W:0]   shifted, diff;

  always_comb begin
    rem_in  = start ? '0 : rem_q;
    quo_in  = start ? dividend : quo_q;
    dvs_in  = start ? divisor : dvs_q;
    shifted = {rem_in, quo_in[DVD_W-1]};
    diff    = shifted - {1'b0, dvs_in};
    if (shifted >= {1'b0, dvs_in}) begin
      rem_nxt = diff[DVS_W-1:0];
      quo_nxt = {quo_in[DVD_W-2:0], 1'b1};
    end else begin
      rem_nxt = shifted[DVS_W-1:0];
      quo_nxt = {quo_in[DVD_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem_q <= rem_nxt;
        quo_q <= quo_nxt;
        dvs_q <= divisor;
        cnt_q <= CW'(DVD_W - 1);
        busy  <= 1'b1;
      end else if (busy) begin
        rem_q <= rem_nxt;
        quo_q <= quo_nxt;
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient = quo_q;

endmodule

// File: rtl/mul_error_accumulator.sv
// Accumulates raw error-metric sums (ER/MED/MNED/MRED/max) of an approximate multiplier
// against the exact product; software divides the sums by the sample count.
module mul_error_accumulator
  import mul_err_pkg::*;
#(
  parameter int unsigned W         = W_DEF,
  parameter int unsigned N_SAMPLES = 10000,
  parameter int unsigned RE_FRAC   = RE_FRAC_DEF,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned ACC_W     = 48
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       a,
  input  logic [W-1:0]       b,
  input  logic [2*W-1:0]     apprx,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   sample_cnt,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [ACC_W-1:0]   sum_ed,
  output logic [ACC_W-1:0]   sum_ed_abs,
  output logic [2*W-1:0]     max_ed,
  output logic [ACC_W-1:0]   sum_re
);

  localparam int unsigned PW = 2 * W;
  localparam int unsigned QW = div_cycles(W, RE_FRAC);

  if (ACC_W < PW + RE_FRAC + $clog2(N_SAMPLES) + 1) begin : g_acc_w_check
    $error("ACC_W too narrow for N_SAMPLES worst case");
  end

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, b_q;
  logic [PW-1:0]   apprx_q, exact, ed_abs;
  logic [PW:0]     ed, neg_ed;
  logic            has_err, need_div, div_start, div_busy, div_done;
  logic [QW-1:0]   quotient;

  assign exact    = PW'(a_q) * PW'(b_q);
  assign ed       = {1'b0, exact} - {1'b0, apprx_q};
  assign neg_ed   = -ed;
  assign ed_abs   = ed[PW] ? neg_ed[PW-1:0] : ed[PW-1:0];
  assign has_err  = (ed != '0);
  assign need_div = has_err && (exact != '0);

  always_comb begin
    state_d   = state_q;
    div_start = 1'b0;
    case (state_q)
      StIdle, StDone: if (start) state_d = StRun;
      StRun:          if (in_valid) state_d = StUpd;
      StUpd: begin
        if (need_div) begin
          state_d   = StDiv;
          div_start = 1'b1;
        end else if (sample_cnt == CNT_W'(N_SAMPLES - 1)) begin
          state_d = StDone;
        end else begin
          state_d = StRun;
        end
      end
      // sample_cnt was already bumped in UPD, so compare against the full count here.
      StDiv: if (div_done) state_d = (sample_cnt == CNT_W'(N_SAMPLES)) ? StDone : StRun;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      apprx_q    <= '0;
      sample_cnt <= '0;
      err_cnt    <= '0;
      sum_ed     <= '0;
      sum_ed_abs <= '0;
      max_ed     <= '0;
      sum_re     <= '0;
    end else begin
      state_q  <= state_d;
      in_ready <= (state_d == StRun);
      busy     <= (state_d inside {StRun, StUpd, StDiv});
      done     <= (state_d == StDone);
      if (state_q == StRun && in_valid) begin
        a_q     <= a;
        b_q     <= b;
        apprx_q <= apprx;
      end
      if ((state_q == StIdle || state_q == StDone) && start) begin
        sample_cnt <= '0;
        err_cnt    <= '0;
        sum_ed     <= '0;
        sum_ed_abs <= '0;
        max_ed     <= '0;
        sum_re     <= '0;
      end
      if (state_q == StUpd) begin
        sample_cnt <= sample_cnt + CNT_W'(1);
        err_cnt    <= err_cnt + CNT_W'(has_err);
        sum_ed     <= sum_ed + {{(ACC_W - PW - 1){ed[PW]}}, ed};
        sum_ed_abs <= sum_ed_abs + ACC_W'(ed_abs);
        if (ed_abs > max_ed) max_ed <= ed_abs;
      end
      if (state_q == StDiv && div_done) sum_re <= sum_re + ACC_W'(quotient);
    end
  end

  mul_err_divider #(
    .DVD_W(QW),
    .DVS_W(PW)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend ({ed_abs, {RE_FRAC{1'b0}}}),
    .divisor  (exact),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (quotient)
  );

  logic unused_div_busy;
  assign unused_div_busy = div_busy;

endmodule

// File: tb/tb_mul_error_accumulator.sv
// Scoreboard bench for mul_error_accumulator with a three-sample run length.
module tb_mul_error_accumulator;

  localparam int NS = 3;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_ready, busy, done;
  logic [7:0]  a, b;
  logic [15:0] apprx, max_ed;
  logic [31:0] sample_cnt, err_cnt;
  logic [47:0] sum_ed, sum_ed_abs, sum_re;

  int checks = 0;
  int errors = 0;

  typedef struct {
    longint      cnt, err, sabs, mx, re;
    logic [47:0] sed;
    int          low;
    bit          last;
  } exp_t;

  exp_t   sb[$];
  longint m_cnt, m_err, m_sed, m_abs, m_max, m_re;

  mul_error_accumulator #(
    .W(8), .N_SAMPLES(NS), .RE_FRAC(16), .CNT_W(32), .ACC_W(48)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .apprx(apprx), .busy(busy), .done(done), .sample_cnt(sample_cnt),
    .err_cnt(err_cnt), .sum_ed(sum_ed), .sum_ed_abs(sum_ed_abs), .max_ed(max_ed),
    .sum_re(sum_re)
  );

  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", tag, act, exp);
    end
  endtask

  task automatic model_clear();
    m_cnt = 0; m_err = 0; m_sed = 0; m_abs = 0; m_max = 0; m_re = 0;
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    model_clear();
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic check_zero(input string pfx);
    check_eq({pfx, "_in_ready"}, in_ready, 0);
    check_eq({pfx, "_busy"}, busy, 0);
    check_eq({pfx, "_done"}, done, 0);
    check_eq({pfx, "_sample_cnt"}, sample_cnt, 0);
    check_eq({pfx, "_err_cnt"}, err_cnt, 0);
    check_eq({pfx, "_sum_ed"}, sum_ed, 0);
    check_eq({pfx, "_sum_ed_abs"}, sum_ed_abs, 0);
    check_eq({pfx, "_max_ed"}, max_ed, 0);
    check_eq({pfx, "_sum_re"}, sum_re, 0);
  endtask

  // Called at a negedge; drives one sample, waits for it to retire, compares against the model.
  task automatic send(input int ai, input int bi, input int ap);
    int     n;
    longint ex, ed, ab;
    exp_t   e;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check_eq("in_ready_wait", in_ready, 1);
      return;
    end
    ex = longint'(ai) * longint'(bi);
    ed = ex - longint'(ap);
    ab = (ed < 0) ? -ed : ed;
    m_cnt++;
    if (ed != 0) m_err++;
    m_sed += ed;
    m_abs += ab;
    if (ab > m_max) m_max = ab;
    if (ex != 0 && ed != 0) m_re += (ab << 16) / ex;
    e.cnt = m_cnt; e.err = m_err; e.sabs = m_abs; e.mx = m_max; e.re = m_re;
    e.sed = m_sed[47:0];
    e.low = (ex != 0 && ed != 0) ? 33 : 1;
    e.last = (m_cnt == NS);
    sb.push_back(e);
    a = 8'(ai); b = 8'(bi); apprx = 16'(ap); in_valid = 1'b1;
    @(negedge clk) in_valid = 1'b0;
    n = 0;
    while (!in_ready && !done && n < 200) begin
      n++;
      @(negedge clk);
    end
    e = sb.pop_front();
    check_eq("ready_low_cycles", 64'(n), 64'(e.low));
    check_eq("sample_cnt", sample_cnt, 64'(e.cnt));
    check_eq("err_cnt", err_cnt, 64'(e.err));
    check_eq("sum_ed", sum_ed, 64'(e.sed));
    check_eq("sum_ed_abs", sum_ed_abs, 64'(e.sabs));
    check_eq("max_ed", max_ed, 64'(e.mx));
    check_eq("sum_re", sum_re, 64'(e.re));
    check_eq("done", done, 64'(e.last));
    check_eq("busy", busy, 64'(!e.last));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; a = '0; b = '0; apprx = '0;
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_zero("reset");

    // Three exact samples complete a run with zero error sums.
    pulse_start();
    send(3, 5, 15);
    send(0, 200, 0);
    send(255, 255, 65025);

    do_reset();
    pulse_start();
    send(10, 10, 96);
    do_reset();
    pulse_start();
    send(1, 2, 5);
    do_reset();
    pulse_start();
    send(0, 9, 7);

    // Reset in the middle of a divide.
    do_reset();
    pulse_start();
    a = 8'd10; b = 8'd10; apprx = 16'd96; in_valid = 1'b1;
    @(negedge clk) in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("mid_div_busy", busy, 1);
    #2 rst = 1'b1;
    #1 check_zero("async_rst");
    @(negedge clk);
    check_zero("rst_edge");
    rst = 1'b0;
    model_clear();
    pulse_start();
    send(10, 10, 96);

    // Start ignored while busy; in_valid ignored in DONE; start from DONE clears.
    do_reset();
    pulse_start();
    send(7, 7, 40);
    pulse_start();
    check_eq("start_in_run_cnt", sample_cnt, 1);
    check_eq("start_in_run_err", err_cnt, 1);
    check_eq("start_in_run_busy", busy, 1);
    send(4, 4, 16);
    send(2, 3, 1);
    @(negedge clk) in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    check_eq("done_valid_ignored", sample_cnt, 3);
    check_eq("done_sticky", done, 1);
    pulse_start();
    model_clear();
    check_eq("restart_busy", busy, 1);
    check_eq("restart_done", done, 0);
    check_eq("restart_cnt", sample_cnt, 0);
    check_eq("restart_sum_ed_abs", sum_ed_abs, 0);
    check_eq("restart_sum_re", sum_re, 0);
    check_eq("restart_max", max_ed, 0);

    // Randomised runs; the first continues the run just restarted.
    for (int r = 0; r < 300; r++) begin
      if (r != 0) begin
        pulse_start();
        model_clear();
      end
      for (int s = 0; s < NS; s++) begin
        int ai, bi, ap, ex, mode;
        ai = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
        bi = int'($urandom_range(0, 255));
        ex = ai * bi;
        mode = int'($urandom_range(0, 3));
        if (mode == 0) ap = ex;
        else if (mode == 1) begin
          ap = ex + int'($urandom_range(0, 20)) - 10;
          if (ap < 0) ap = 0;
          if (ap > 65535) ap = 65535;
        end else ap = int'($urandom_range(0, 65535));
        send(ai, bi, ap);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
